// File: rtl/rk_sdspi_pkg.sv
// Shared constants for the rk_sdspi SD-card SPI byte engine.
// Register offsets, CTRL bit positions and FSM state encoding.
package rk_sdspi_pkg;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_DATA = 2'd1;
    localparam logic [1:0] REG_DIV  = 2'd2;

    localparam int CTRL_CS     = 0;
    localparam int CTRL_FAST   = 1;
    localparam int STATUS_BUSY = 7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;

    localparam logic MOSI_IDLE = 1'b1;

endpackage

// File: rtl/rk_sdspi_tick.sv
// Half-period timer: pulses tick_o every reload+1 enabled clocks.
// load_i captures both the live count and the reload value.
module rk_sdspi_tick (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_i,
    input  logic       en_i,
    input  logic [7:0] hval_i,
    output logic       tick_o
);

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] rel_q, rel_d;

    assign tick_o = en_i && (cnt_q == 8'd0);

    always_comb begin
        cnt_d = cnt_q;
        rel_d = rel_q;
        if (load_i) begin
            cnt_d = hval_i;
            rel_d = hval_i;
        end else if (en_i) begin
            cnt_d = tick_o ? rel_q : cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 8'd0;
            rel_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
            rel_q <= rel_d;
        end
    end

endmodule

// File: rtl/rk_sdspi.sv
// CPU-mapped SD-card SPI byte engine (mode 0, MSB first).
// Define SDSPI_AUTOREAD_EN to let a DATA read start the next 0xFF transfer.
module rk_sdspi
    import rk_sdspi_pkg::*;
#(
    parameter logic [7:0] DIV_SLOW = 8'd62,
    parameter logic [7:0] DIV_FAST = 8'd1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] addr,
    input  logic [7:0] idata,
    input  logic       we_n,
    input  logic       rd_n,
    output logic [7:0] odata,
    output logic       busy,
    output logic       sd_cs_n,
    output logic       sd_sck,
    output logic       sd_mosi,
    input  logic       sd_miso
);

    logic       we_q, rd_q, miso_q;
    logic [1:0] state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic       samp_q, samp_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] rx_q, rx_d;
    logic       cs_q, cs_d;
    logic       fast_q, fast_d;
    logic [7:0] div_q, div_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;

    logic       wr_edge, rd_edge, idle;
    logic       start_wr, start_rd, start;
    logic [7:0] tx_byte, h_new;
    logic       tick;

    assign wr_edge  = !we_n && we_q;
    assign rd_edge  = !rd_n && rd_q;
    assign idle     = (state_q == ST_IDLE);
    assign start_wr = wr_edge && idle && (addr == REG_DATA);

`ifdef SDSPI_AUTOREAD_EN
    // A coincident write edge wins; the read is then side-effect free.
    assign start_rd = rd_edge && !wr_edge && idle && (addr == REG_DATA);
`else
    logic unused_rd;
    assign unused_rd = rd_edge;
    assign start_rd  = 1'b0;
`endif

    assign start   = start_wr || start_rd;
    assign tx_byte = start_wr ? idata : 8'hFF;
    assign h_new   = fast_q ? DIV_FAST : div_q;

    rk_sdspi_tick u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (start),
        .en_i    (!idle),
        .hval_i  (h_new),
        .tick_o  (tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        samp_d  = samp_q;
        bit_d   = bit_q;
        rx_d    = rx_q;
        cs_d    = cs_q;
        fast_d  = fast_q;
        div_d   = div_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d = tx_byte;
                    mosi_d  = tx_byte[7];
                    bit_d   = 3'd0;
                    state_d = ST_LO;
                end else if (wr_edge) begin
                    if (addr == REG_CTRL) begin
                        cs_d   = idata[CTRL_CS];
                        fast_d = idata[CTRL_FAST];
                    end else if (addr == REG_DIV) begin
                        div_d = idata;
                    end
                end
            end
            ST_LO: begin
                if (tick) begin
                    sck_d   = 1'b1;
                    samp_d  = miso_q;
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (tick) begin
                    sck_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        rx_d    = {shift_q[6:0], samp_q};
                        mosi_d  = MOSI_IDLE;
                        state_d = ST_IDLE;
                    end else begin
                        shift_d = {shift_q[6:0], samp_q};
                        mosi_d  = shift_q[6];
                        bit_d   = bit_q + 3'd1;
                        state_d = ST_LO;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b1;
            rd_q    <= 1'b1;
            miso_q  <= 1'b1;
            state_q <= ST_IDLE;
            shift_q <= 8'hFF;
            samp_q  <= 1'b1;
            bit_q   <= 3'd0;
            rx_q    <= 8'hFF;
            cs_q    <= 1'b0;
            fast_q  <= 1'b0;
            div_q   <= DIV_SLOW;
            sck_q   <= 1'b0;
            mosi_q  <= MOSI_IDLE;
        end else begin
            we_q    <= we_n;
            rd_q    <= rd_n;
            miso_q  <= sd_miso;
            state_q <= state_d;
            shift_q <= shift_d;
            samp_q  <= samp_d;
            bit_q   <= bit_d;
            rx_q    <= rx_d;
            cs_q    <= cs_d;
            fast_q  <= fast_d;
            div_q   <= div_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
        end
    end

    assign busy    = !idle;
    assign sd_cs_n = !cs_q;
    assign sd_sck  = sck_q;
    assign sd_mosi = mosi_q;

    always_comb begin
        odata = 8'h00;
        unique case (addr)
            REG_CTRL: odata = {busy, 5'b0, fast_q, cs_q};
            REG_DATA: odata = rx_q;
            REG_DIV:  odata = div_q;
            default:  odata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_rk_sdspi.sv
// Self-checking bench for rk_sdspi against a byte-level SPI reference model.
// Expected RX, MOSI bits, busy length and SCK period come from the protocol rules.
module tb_rk_sdspi;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] idata = 8'h00;
    logic       we_n = 1'b1;
    logic       rd_n = 1'b1;
    logic       sd_miso = 1'b1;
    logic [7:0] odata;
    logic       busy, sd_cs_n, sd_sck, sd_mosi;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_div;
    logic [7:0] exp_rx;

    rk_sdspi dut (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (addr),
        .idata   (idata),
        .we_n    (we_n),
        .rd_n    (rd_n),
        .odata   (odata),
        .busy    (busy),
        .sd_cs_n (sd_cs_n),
        .sd_sck  (sd_sck),
        .sd_mosi (sd_mosi),
        .sd_miso (sd_miso)
    );

    always #5 clk = ~clk;

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a;
        idata = d;
        we_n = 1'b0;
        @(negedge clk);
        we_n = 1'b1;
    endtask

    // One byte transfer; the card side answers with pat (or echoes MOSI when loop=1).
    task automatic do_xfer(input logic [7:0] tx, input logic [7:0] pat, input int h,
                           input bit loop, input bit hold, input bit by_read,
                           input string nm);
        int busy_cyc = 0;
        int rises = 0;
        int last = 0;
        int per_bad = 0;
        int cs_bad = 0;
        int bitn = 0;
        logic [7:0] got = 8'h00;
        logic prev = 1'b0;
        logic cs0;
        logic [7:0] exp;
        exp = loop ? tx : pat;
        @(negedge clk);
        sd_miso = loop ? 1'b1 : pat[7];
        addr = 2'd1;
        idata = tx;
        cs0 = sd_cs_n;
        if (by_read) begin
            rd_n = 1'b0;
            #1;
            total++;
            if (odata !== exp_rx) begin
                bad++;
                $display("FAIL %s autoread_data got=%h exp=%h", nm, odata, exp_rx);
            end
        end else begin
            we_n = 1'b0;
        end
        for (int cyc = 1; cyc <= 16 * (h + 1) + 40; cyc++) begin
            @(negedge clk);
            if (!hold) we_n = 1'b1;
            rd_n = 1'b1;
            if (busy) busy_cyc++;
            if (sd_sck && !prev) begin
                if (rises < 8) got[7 - rises] = sd_mosi;
                if (rises > 0 && (cyc - last) != 2 * (h + 1)) per_bad++;
                last = cyc;
                rises++;
            end
            if (!sd_sck && prev) begin
                bitn++;
                if (!loop && bitn < 8) sd_miso = pat[7 - bitn];
            end
            if (loop) sd_miso = sd_mosi;
            if (sd_cs_n !== cs0) cs_bad++;
            prev = sd_sck;
        end
        exp_rx = exp;
        total++;
        if (busy_cyc != 16 * (h + 1)) begin
            bad++;
            $display("FAIL %s busy_len got=%0d exp=%0d", nm, busy_cyc, 16 * (h + 1));
        end
        total++;
        if (rises != 8 || per_bad != 0) begin
            bad++;
            $display("FAIL %s sck rises=%0d exp=8 bad_periods=%0d", nm, rises, per_bad);
        end
        total++;
        if (got !== tx) begin
            bad++;
            $display("FAIL %s mosi got=%h exp=%h", nm, got, tx);
        end
        total++;
        if (cs_bad != 0) begin
            bad++;
            $display("FAIL %s cs_toggled count=%0d exp=0", nm, cs_bad);
        end
        total++;
        if (odata !== exp || sd_mosi !== 1'b1) begin
            bad++;
            $display("FAIL %s rx got=%h exp=%h mosi=%b", nm, odata, exp, sd_mosi);
        end
    endtask

    task automatic test_reset();
        int falls = 0;
        logic prev = 1'b0;
        bit reached = 0;
        repeat (3) @(negedge clk);
        total++;
        if (sd_cs_n !== 1'b1 || sd_sck !== 1'b0 || sd_mosi !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_pins got cs_n=%b sck=%b mosi=%b busy=%b exp 1 0 1 0",
                     sd_cs_n, sd_sck, sd_mosi, busy);
        end
        reset_n = 1'b1;
        exp_div = 8'd62;
        exp_rx = 8'hFF;
        @(negedge clk);
        addr = 2'd1;
        #1;
        total++;
        if (odata !== 8'hFF) begin
            bad++;
            $display("FAIL reset_rx got=%h exp=ff", odata);
        end
        cpu_write(2'd0, 8'h01);
        cpu_write(2'd1, 8'hA5);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!sd_sck && prev) falls++;
            prev = sd_sck;
            if (falls == 3) begin
                repeat (10) @(negedge clk);
                reached = 1;
                break;
            end
        end
        total++;
        if (!reached || busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_reach_bit3 reached=%0d busy=%b exp 1 1", reached, busy);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (sd_cs_n !== 1'b1 || sd_sck !== 1'b0 || busy !== 1'b0 || odata !== 8'hFF) begin
            bad++;
            $display("FAIL reset_mid got cs_n=%b sck=%b busy=%b rx=%h exp 1 0 0 ff",
                     sd_cs_n, sd_sck, busy, odata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        addr = 2'd2;
        #1;
        total++;
        if (odata !== 8'd62) begin
            bad++;
            $display("FAIL reset_div got=%0d exp=62", odata);
        end
        addr = 2'd0;
        #1;
        total++;
        if (odata !== 8'h00) begin
            bad++;
            $display("FAIL reset_ctrl got=%h exp=00", odata);
        end
    endtask

    task automatic test_loopback();
        cpu_write(2'd0, 8'h03);
        do_xfer(8'hA5, 8'h00, 1, 1, 0, 0, "loopback");
    endtask

    task automatic test_div0();
        cpu_write(2'd0, 8'h01);
        cpu_write(2'd2, 8'h00);
        exp_div = 8'h00;
        do_xfer(8'h00, 8'hFF, 0, 0, 0, 0, "div0");
        addr = 2'd2;
        #1;
        total++;
        if (odata !== exp_div) begin
            bad++;
            $display("FAIL div0_readback got=%h exp=%h", odata, exp_div);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            logic [7:0] d;
            logic f;
            d = 8'($urandom_range(1, 4));
            f = 1'($urandom % 2);
            cpu_write(2'd2, d);
            exp_div = d;
            cpu_write(2'd0, {6'b0, f, 1'b1});
            do_xfer(8'($urandom), 8'($urandom), f ? 1 : int'(d), 0, 0, 0, "random");
        end
    endtask

    task automatic test_hold();
        int extra = 0;
        logic prev = 1'b0;
        cpu_write(2'd0, 8'h03);
        do_xfer(8'h3C, 8'($urandom), 1, 0, 1, 0, "hold");
        for (int i = 0; i < 470; i++) begin
            @(negedge clk);
            if (sd_sck && !prev) extra++;
            if (busy) extra++;
            prev = sd_sck;
        end
        we_n = 1'b1;
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL hold_repeat activity=%0d exp=0", extra);
        end
    endtask

    task automatic test_busy_write();
        cpu_write(2'd0, 8'h03);
        @(negedge clk);
        sd_miso = 1'b0;
        cpu_write(2'd1, 8'h55);
        cpu_write(2'd0, 8'h00);
        cpu_write(2'd2, 8'h09);
        cpu_write(2'd1, 8'hFF);
        addr = 2'd0;
        #1;
        total++;
        if (sd_cs_n !== 1'b0 || odata !== 8'h83) begin
            bad++;
            $display("FAIL busy_ctrl got cs_n=%b ctrl=%h exp 0 83", sd_cs_n, odata);
        end
        repeat (28) @(negedge clk);
        addr = 2'd1;
        #1;
        total++;
        if (busy !== 1'b0 || odata !== 8'h00) begin
            bad++;
            $display("FAIL busy_done got busy=%b rx=%h exp 0 00", busy, odata);
        end
        exp_rx = 8'h00;
        addr = 2'd2;
        #1;
        total++;
        if (odata !== exp_div) begin
            bad++;
            $display("FAIL busy_div got=%h exp=%h", odata, exp_div);
        end
        cpu_write(2'd0, 8'h00);
        #1;
        total++;
        if (sd_cs_n !== 1'b1) begin
            bad++;
            $display("FAIL busy_cs_release got=%b exp=1", sd_cs_n);
        end
    endtask

    task automatic test_read();
        cpu_write(2'd0, 8'h03);
        do_xfer(8'($urandom), 8'h12, 1, 0, 0, 0, "pre_read");
`ifdef SDSPI_AUTOREAD_EN
        do_xfer(8'hFF, 8'h00, 1, 0, 0, 1, "autoread");
`else
        begin
            int act = 0;
            @(negedge clk);
            addr = 2'd1;
            rd_n = 1'b0;
            @(negedge clk);
            rd_n = 1'b1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (busy || sd_sck) act++;
            end
            total++;
            if (act != 0 || odata !== 8'h12) begin
                bad++;
                $display("FAIL read_no_start activity=%0d rx=%h exp 0 12", act, odata);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_div0();
        test_random();
        test_hold();
        test_busy_write();
        test_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
